core_seq_ctrl: RTL and testbench

Hardware sequencer that generates the 34-bit core instruction word so the core runs a full convolution pass without a testbench driving it. On `start` it walks all kij phases:
- weight load XMEM->L0->PE
- activation streaming and execute
- OFIFO drain to PMEM

It then runs the PMEM accumulation pass for every output pixel. It sits between the top-level host interface and the core's `inst` input.

---
 rtl/core_seq_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Sequencer that emits the 34-bit core instruction word for a full conv pass plus PMEM accumulation.
// All outputs registered; first WLD instruction appears the cycle after start is sampled.
// Stalls in OWAIT on ofifo_valid; CORE_SEQ_TIMEOUT_EN bounds that wait to TIMEOUT cycles.
module core_seq_ctrl #(
  parameter int col            = 8,
  parameter int len_kij        = 9,
  parameter int len_kij_dim_1  = 3,
  parameter int len_nij        = 36,
  parameter int len_nij_dim_1  = 6,
  parameter int len_onij       = 16,
  parameter int len_onij_dim_1 = 4,
  parameter int XBASE          = 0,
  parameter int WBASE          = 1024,
  parameter int TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic        psum_clr,
  output logic        out_strobe,
  output logic [4:0]  onij_idx,
  output logic        timeout_err
);

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_WGAP, S_XEX, S_OWAIT, S_OF2P, S_ACC, S_DONE
  } state_t;

  localparam logic [33:0] INST_IDLE = 34'h1800C0000;
  localparam int CW = $clog2(len_nij + 2 * col + TIMEOUT + len_kij + 4);
  localparam int KW = (len_kij > 1) ? $clog2(len_kij) : 1;

  localparam logic [CW-1:0] WLD_LAST  = CW'(2 * col);
  localparam logic [CW-1:0] WGAP_LAST = CW'(col - 1);
  localparam logic [CW-1:0] XEX_LAST  = CW'(len_nij + col);
  localparam logic [CW-1:0] OF2P_LAST = CW'(len_nij);
  localparam logic [CW-1:0] ACC_LAST  = CW'(len_kij + 2);
  localparam logic [KW-1:0] KIJ_LAST  = KW'(len_kij - 1);
  localparam logic [4:0]    ONIJ_LAST = 5'(len_onij - 1);

  state_t        state, state_n;
  logic [CW-1:0] c, c_n;
  logic [KW-1:0] kij, kij_n;
  logic [4:0]    onij, onij_n;
  logic          adv;
  inst_t         inst_n;
  logic          busy_n, done_n, clr_n, strobe_n;
  int            cint, kint, oint, j;

`ifdef CORE_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic to_hit;
  logic terr_q;
`endif

  always_comb begin
    state_n = state;
    c_n     = c + 1'b1;
    kij_n   = kij;
    onij_n  = onij;
    adv     = 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
    to_hit  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        c_n = '0;
        if (start) begin
          state_n = S_WLD;
          kij_n   = '0;
          onij_n  = '0;
        end
      end
      S_WLD:  if (c == WLD_LAST)  begin state_n = S_WGAP;  c_n = '0; end
      S_WGAP: if (c == WGAP_LAST) begin state_n = S_XEX;   c_n = '0; end
      S_XEX:  if (c == XEX_LAST)  begin state_n = S_OWAIT; c_n = '0; end
      S_OWAIT: begin
        if (ofifo_valid) begin
          state_n = S_OF2P;
          c_n     = '0;
        end
`ifdef CORE_SEQ_TIMEOUT_EN
        else if (c == TO_LAST) begin
          to_hit = 1'b1;
          adv    = 1'b1;
        end
`else
        else c_n = '0;
`endif
      end
      S_OF2P: if (c == OF2P_LAST) adv = 1'b1;
      S_ACC: begin
        if (c == ACC_LAST) begin
          c_n = '0;
          if (onij == ONIJ_LAST) state_n = S_DONE;
          else onij_n = onij + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        c_n     = '0;
      end
      default: begin
        state_n = S_IDLE;
        c_n     = '0;
      end
    endcase

    // Finished (or skipped) drain: next kernel position, or accumulate once all are done
    if (adv) begin
      c_n = '0;
      if (kij == KIJ_LAST) begin
        state_n = S_ACC;
        onij_n  = '0;
      end else begin
        state_n = S_WLD;
        kij_n   = kij + 1'b1;
      end
    end

    // Outputs are decoded from the state being entered so they register in step with it
    inst_n   = INST_IDLE;
    busy_n   = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n   = (state_n == S_DONE);
    clr_n    = 1'b0;
    strobe_n = 1'b0;
    cint     = int'(c_n);
    kint     = int'(kij_n);
    oint     = int'(onij_n);
    j        = cint - 1;
    case (state_n)
      S_WLD: begin
        if (cint < col) begin
          inst_n.cen_xmem = 1'b0;
          inst_n.a_xmem   = 11'(WBASE + kint * col + cint);
        end
        inst_n.l0_wr = (cint >= 1) && (cint <= col);
        inst_n.l0_rd = (cint >= 2) && (cint <= 2 * col);
        inst_n.load  = (cint >= 2) && (cint <= col + 1);
      end
      S_XEX: begin
        if (cint < len_nij) begin
          inst_n.cen_xmem = 1'b0;
          inst_n.a_xmem   = 11'(XBASE + cint);
        end
        inst_n.l0_wr   = (cint >= 1) && (cint <= len_nij);
        inst_n.l0_rd   = (cint >= 2) && (cint <= len_nij + col);
        inst_n.execute = (cint >= 2) && (cint <= len_nij + 1);
      end
      S_OF2P: begin
        inst_n.ofifo_rd = (cint < len_nij);
        if (cint >= 1) begin
          inst_n.cen_pmem = 1'b0;
          inst_n.wen_pmem = 1'b0;
          inst_n.a_pmem   = 11'(kint * len_nij + cint - 1);
        end
      end
      S_ACC: begin
        clr_n = (cint == 0);
        if ((cint >= 1) && (cint <= len_kij)) begin
          inst_n.cen_pmem = 1'b0;
          inst_n.a_pmem   = 11'(j * len_nij
                                + (oint / len_onij_dim_1) * len_nij_dim_1 + oint % len_onij_dim_1
                                + (j / len_kij_dim_1) * len_nij_dim_1 + j % len_kij_dim_1);
        end
        inst_n.acc = (cint >= 2) && (cint <= len_kij + 1);
        strobe_n   = (cint == len_kij + 2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      c          <= '0;
      kij        <= '0;
      onij       <= '0;
      inst       <= INST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      psum_clr   <= 1'b0;
      out_strobe <= 1'b0;
      onij_idx   <= '0;
    end else begin
      state      <= state_n;
      c          <= c_n;
      kij        <= kij_n;
      onij       <= onij_n;
      inst       <= inst_n;
      busy       <= busy_n;
      done       <= done_n;
      psum_clr   <= clr_n;
      out_strobe <= strobe_n;
      onij_idx   <= onij_n;
    end
  end

`ifdef CORE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) terr_q <= 1'b0;
    else        terr_q <= terr_q | to_hit;
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: builds the expected per-cycle instruction trace of a pass from the phase rules
// and compares every registered output against it, with random OFIFO waits and ignored start pulses.
module tb_core_seq_ctrl;
  localparam int COL = 8, KIJ = 9, KD = 3, NIJ = 36, ND = 6, ONIJ = 16, OD = 4;
  localparam int XB = 0, WB = 1024, TO = 64;
  localparam logic [33:0] IDLE_I = 34'h1800C0000;
`ifdef CORE_SEQ_TIMEOUT_EN
  localparam int LONG_WAIT = 1000;
  localparam int TOTAL_WR  = 288;
  localparam bit TERR_END  = 1'b1;
`else
  localparam int LONG_WAIT = 100;
  localparam int TOTAL_WR  = 324;
  localparam bit TERR_END  = 1'b0;
`endif

  logic        clk, reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        busy, done, psum_clr, out_strobe, timeout_err;
  logic [4:0]  onij_idx;

  core_seq_ctrl #(
    .col(COL), .len_kij(KIJ), .len_kij_dim_1(KD), .len_nij(NIJ), .len_nij_dim_1(ND),
    .len_onij(ONIJ), .len_onij_dim_1(OD), .XBASE(XB), .WBASE(WB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid), .inst(inst),
    .busy(busy), .done(done), .psum_clr(psum_clr), .out_strobe(out_strobe),
    .onij_idx(onij_idx), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] inst;
    bit          busy;
    bit          done;
    bit          clr;
    bit          strobe;
    int          onij;
    bit          terr;
  } exp_t;

  exp_t exp_q[$];
  bit   vld_q[$];
  exp_t ce;
  int   n_tests = 0, n_fail = 0, cyc = 0, next_v = -1, acc_idx = 0, done_idx = 0;
  int   wait_cyc[KIJ], wld_idx[KIJ], of2p_idx[KIJ];
  bit   armed = 1'b0, model_terr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  function automatic logic [33:0] xrd(input logic [33:0] i, input int a);
    i[19]   = 1'b0;
    i[17:7] = a[10:0];
    return i;
  endfunction

  function automatic logic [33:0] pacc(input logic [33:0] i, input int a, input bit wr);
    i[32]    = 1'b0;
    i[31]    = ~wr;
    i[30:20] = a[10:0];
    return i;
  endfunction

  task automatic push(input logic [33:0] i, input bit b, input bit d, input bit clr, input bit st, input int o);
    exp_t e;
    e.inst = i; e.busy = b; e.done = d; e.clr = clr; e.strobe = st; e.onij = o; e.terr = model_terr;
    exp_q.push_back(e);
    if (next_v >= 0) vld_q.push_back(next_v == 1);
    else             vld_q.push_back($urandom_range(0, 1) == 1);
    next_v = -1;
  endtask

  // Expected trace of one pass; vld_q[k] is the ofifo_valid seen at the edge producing exp_q[k]
  task automatic build_pass();
    logic [33:0] i;
    int n, a, jj;
    bit timed;
    exp_q.delete(); vld_q.delete(); next_v = -1;
    for (int kij = 0; kij < KIJ; kij++) begin
      wld_idx[kij] = exp_q.size(); of2p_idx[kij] = -1;
      for (int c = 0; c <= 2 * COL; c++) begin
        i = IDLE_I;
        if (c < COL) i = xrd(i, WB + kij * COL + c);
        if (c >= 1 && c <= COL) i[2] = 1'b1;
        if (c >= 2 && c <= 2 * COL) i[3] = 1'b1;
        if (c >= 2 && c <= COL + 1) i[0] = 1'b1;
        push(i, 1, 0, 0, 0, 0);
      end
      for (int c = 0; c < COL; c++) push(IDLE_I, 1, 0, 0, 0, 0);
      for (int c = 0; c <= NIJ + COL; c++) begin
        i = IDLE_I;
        if (c < NIJ) i = xrd(i, XB + c);
        if (c >= 1 && c <= NIJ) i[2] = 1'b1;
        if (c >= 2 && c <= NIJ + COL) i[3] = 1'b1;
        if (c >= 2 && c <= NIJ + 1) i[1] = 1'b1;
        push(i, 1, 0, 0, 0, 0);
      end
`ifdef CORE_SEQ_TIMEOUT_EN
      timed = wait_cyc[kij] > TO;
`else
      timed = 1'b0;
`endif
      n = timed ? TO : wait_cyc[kij];
      for (int w = 0; w < n; w++) begin
        if (w >= 1) next_v = 0;
        push(IDLE_I, 1, 0, 0, 0, 0);
      end
      if (timed) begin
        next_v = 0;
        model_terr = 1'b1;
      end else begin
        next_v = 1;
        of2p_idx[kij] = exp_q.size();
        for (int c = 0; c <= NIJ; c++) begin
          i = IDLE_I;
          if (c < NIJ) i[6] = 1'b1;
          if (c >= 1) i = pacc(i, kij * NIJ + c - 1, 1'b1);
          push(i, 1, 0, 0, 0, 0);
        end
      end
    end
    acc_idx = exp_q.size();
    for (int o = 0; o < ONIJ; o++) begin
      for (int c = 0; c <= KIJ + 2; c++) begin
        i = IDLE_I;
        if (c >= 1 && c <= KIJ) begin
          jj = c - 1;
          a  = jj * NIJ + (o / OD) * ND + o % OD + (jj / KD) * ND + jj % KD;
          i  = pacc(i, a, 1'b0);
        end
        if (c >= 2 && c <= KIJ + 1) i[33] = 1'b1;
        push(i, 1, 0, c == 0, c == KIJ + 2, o);
      end
    end
    push(IDLE_I, 0, 1, 0, 0, 0);
    done_idx = exp_q.size() - 1;
    push(IDLE_I, 0, 0, 0, 0, 0);
    push(IDLE_I, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (armed && exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      n_tests++;
      if (inst !== ce.inst || busy !== ce.busy || done !== ce.done || psum_clr !== ce.clr ||
          out_strobe !== ce.strobe || timeout_err !== ce.terr ||
          (ce.strobe && onij_idx !== 5'(ce.onij))) begin
        n_fail++;
        $display("FAIL trace cyc %0d: inst=%h busy=%b done=%b clr=%b strobe=%b onij=%0d terr=%b; expected inst=%h busy=%b done=%b clr=%b strobe=%b onij=%0d terr=%b",
                 cyc, inst, busy, done, psum_clr, out_strobe, onij_idx, timeout_err,
                 ce.inst, ce.busy, ce.done, ce.clr, ce.strobe, ce.onij, ce.terr);
      end
      cyc++;
    end
  end

  task automatic run_pass(input int limit);
    for (int k = 0; k < vld_q.size() && k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b1;
        armed = 1'b1;
      end else if (k <= done_idx + 1) start = ($urandom_range(0, 3) == 0);
      else start = 1'b0;
      ofifo_valid = vld_q[k];
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pass(input string nm);
    for (int t = 0; t < 4 && exp_q.size() != 0; t++) @(negedge clk);
    chk(nm, 64'(exp_q.size()), 64'd0);
    armed = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_inst"}, 64'(inst), 64'(IDLE_I));
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_clr"}, 64'(psum_clr), 64'd0);
    chk({nm, "_strobe"}, 64'(out_strobe), 64'd0);
    chk({nm, "_onij"}, 64'(onij_idx), 64'd0);
    chk({nm, "_terr"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic pin_model();
    logic [33:0] t;
    int exec_n = 0, wr_n = 0, st_n = 0, done_n = 0, clr_n = 0, gap_ok = 0, last = -1;
    int ld_n = 0, wr0_n = 0, rd_n = 0, xs;
    t = exp_q[wld_idx[0]].inst;     chk("model_wld0_first_addr", 64'(t[17:7]), 64'd1024);
    t = exp_q[wld_idx[0] + 7].inst; chk("model_wld0_last_addr", 64'(t[17:7]), 64'd1031);
    t = exp_q[wld_idx[3]].inst;     chk("model_wld3_addr", 64'(t[17:7]), 64'd1048);
    t = exp_q[wld_idx[0] + 2].inst; chk("model_first_load", 64'(t[0]), 64'd1);
    t = exp_q[of2p_idx[2] + 1].inst;   chk("model_of2p2_first", 64'(t[30:20]), 64'd72);
    t = exp_q[of2p_idx[2] + NIJ].inst; chk("model_of2p2_last", 64'(t[30:20]), 64'd107);
    t = exp_q[acc_idx + 5 * 12 + 5].inst; chk("model_acc_o5_j4", 64'(t[30:20]), 64'd158);
    for (int k = wld_idx[0]; k <= wld_idx[0] + 2 * COL; k++) begin
      t = exp_q[k].inst;
      if (t[0]) ld_n++;
      if (t[2]) wr0_n++;
    end
    xs = wld_idx[0] + 3 * COL + 1;
    for (int k = xs; k <= xs + NIJ + COL; k++) begin
      t = exp_q[k].inst;
      if (t[3]) rd_n++;
    end
    foreach (exp_q[k]) begin
      t = exp_q[k].inst;
      if (t[1]) exec_n++;
      if (!t[32] && !t[31]) wr_n++;
      if (exp_q[k].clr) clr_n++;
      if (exp_q[k].done) done_n++;
      if (exp_q[k].strobe) begin
        st_n++;
        if (last >= 0 && k - last == 12) gap_ok++;
        last = k;
      end
    end
    chk("model_wld0_load_n", 64'(ld_n), 64'd8);
    chk("model_wld0_l0wr_n", 64'(wr0_n), 64'd8);
    chk("model_xex0_l0rd_n", 64'(rd_n), 64'd43);
    chk("model_exec_n", 64'(exec_n), 64'd324);
    chk("model_pmem_wr_n", 64'(wr_n), 64'(TOTAL_WR));
    chk("model_strobe_n", 64'(st_n), 64'd16);
    chk("model_strobe_gap", 64'(gap_ok), 64'd15);
    chk("model_clr_n", 64'(clr_n), 64'd16);
    chk("model_done_n", 64'(done_n), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
    #12;
    chk_reset("por");
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // Pass aborted by asynchronous reset in the middle of kij=0 XEX
    for (int k = 0; k < KIJ; k++) wait_cyc[k] = 3;
    build_pass();
    run_pass(40);
    #2 reset = 1'b0;
    armed = 1'b0;
    #1 chk_reset("abort");
    exp_q.delete();
    model_terr = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Directed waits: 10-cycle hold on kij=2, a long/never wait on kij=5, the TIMEOUT-1 boundary on kij=6
    wait_cyc = '{1, 3, 11, 2, 7, LONG_WAIT, 64, 1, 5};
    build_pass();
    pin_model();
    run_pass(100000);
    finish_pass("pass1_drain");
    chk("pass1_terr_end", 64'(timeout_err), 64'(TERR_END));

    repeat (2) @(negedge clk);
    for (int k = 0; k < KIJ; k++) wait_cyc[k] = $urandom_range(1, 12);
    build_pass();
    run_pass(100000);
    finish_pass("pass2_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
